// File: rtl/ab_seq_player.sv
// ab_seq_player
//
// Plays a small programmable pattern of {A,B} symbols into the two-input
// sequence detector and records how the detector responded.
//
// Flow: load up to DEPTH symbols through the write port while idle, then
// raise start. The block then:
//   - resets the detector for one cycle (CLEAR);
//   - plays one symbol per clock (RUN);
//   - pulses done (DONE) and returns to IDLE.
// While RUN is active it counts cycles with det_y = 1 and remembers the
// index of the first hit.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data   pattern memory write port (ignored while busy)
//   len                 symbols to play, clamped to DEPTH, sampled at start
//   start               begin a run (ignored while busy)
//   busy                high whenever the sequencer is not idle
//   done                one-cycle pulse at the end of a run
//   det_rst             registered reset to the detector, high in CLEAR only
//   det_a, det_b        detector inputs, zero outside RUN
//   det_y               detector output, sampled every RUN cycle
//   hit_count           saturating count of RUN cycles with det_y = 1
//   first_hit           index of the first symbol that produced a hit
//   hit_valid           at least one hit occurred in the last run
module ab_seq_player #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_data,
  input  logic [AW:0]   len,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          det_rst,
  output logic          det_a,
  output logic          det_b,
  input  logic          det_y,
  output logic [CW-1:0] hit_count,
  output logic [AW-1:0] first_hit,
  output logic          hit_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] MAX_LEN = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW + 1)'(1);

  state_t          state_q, state_d;
  logic [1:0]      mem_q [DEPTH];
  logic [AW:0]     n_q;
  logic [AW-1:0]   idx_q;
  logic [CW-1:0]   hit_count_q;
  logic [AW-1:0]   first_hit_q;
  logic            hit_valid_q;
  logic            done_q;
  logic            det_rst_q;
  logic            last_sym;

  // The symbol being played is the last one when idx reaches n-1.
  // n_q is never zero while in RUN, so the subtraction cannot wrap there.
  assign last_sym = ({1'b0, idx_q} == (n_q - ONE));

  // Next-state selection; CLEAR skips RUN entirely for an empty run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = (n_q == '0) ? DONE : RUN;
      RUN:     if (last_sym) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All sequencer state, the pattern memory and the result registers.
  // det_rst and done are registered from the next state so they line up
  // exactly with the CLEAR and DONE cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      hit_count_q <= '0;
      first_hit_q <= '0;
      hit_valid_q <= 1'b0;
      done_q      <= 1'b0;
      det_rst_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 2'b00;
      end
    end else begin
      state_q   <= state_d;
      det_rst_q <= (state_d == CLEAR);
      done_q    <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
          end
          if (start) begin
            n_q         <= (len > MAX_LEN) ? MAX_LEN : len;
            idx_q       <= '0;
            hit_count_q <= '0;
            first_hit_q <= '0;
            hit_valid_q <= 1'b0;
          end
        end
        RUN: begin
          // det_y belongs to the symbol driven in this same cycle.
          if (det_y) begin
            if (hit_count_q != {CW{1'b1}}) begin
              hit_count_q <= hit_count_q + CW'(1);
            end
            if (!hit_valid_q) begin
              first_hit_q <= idx_q;
              hit_valid_q <= 1'b1;
            end
          end
          idx_q <= idx_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Detector inputs follow the memory directly so each symbol and its
  // det_y response fall in the same cycle.
  assign {det_a, det_b} = (state_q == RUN) ? mem_q[idx_q] : 2'b00;

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign det_rst   = det_rst_q;
  assign hit_count = hit_count_q;
  assign first_hit = first_hit_q;
  assign hit_valid = hit_valid_q;

endmodule
